// File: rtl/tree_input_packer_if.sv
// Stream-in / packed-group-out bundle for tree_input_packer.
// master = packer side, slave = upstream source plus downstream tree.
interface tree_input_packer_if #(
    parameter int pDATA_WIDTH = 32,
    parameter int pINPUT_NUM  = 4
);
    localparam int CW = $clog2(pINPUT_NUM + 1);

    logic                            s_valid;
    logic                            s_ready;
    logic [pDATA_WIDTH-1:0]          s_data;
    logic                            s_last;
    logic                            m_valid;
    logic                            m_ready;
    logic [pDATA_WIDTH*pINPUT_NUM-1:0] m_data;
    logic [CW-1:0]                   m_count;
    logic                            m_last;

    modport master (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data,
        output m_count,
        output m_last
    );

    modport slave (
        output s_valid,
        output s_data,
        output s_last,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_count,
        input  m_last
    );
endinterface

// File: rtl/tree_input_packer.sv
// Packs a signed operand stream into zero-padded lane groups
// for the ShuffleNet adder tree; groups close on full or s_last.
module tree_input_packer #(
    parameter int pDATA_WIDTH = 32,
    parameter int pINPUT_NUM  = 4
) (
    input  logic               clk,
    input  logic               rst,
    tree_input_packer_if.master bus
);
    localparam int IW = (pINPUT_NUM > 1) ? $clog2(pINPUT_NUM) : 1;
    localparam int CW = $clog2(pINPUT_NUM + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [pINPUT_NUM-1:0][pDATA_WIDTH-1:0] lanes_t;

    state_t        state_q, state_d;
    lanes_t        lanes_q, lanes_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_q,  last_d;
    logic          close;

    assign close = (idx_q == IW'(pINPUT_NUM - 1)) || bus.s_last;

    always_comb begin
        state_d = state_q;
        lanes_d = lanes_q;
        idx_d   = idx_q;
        count_d = count_q;
        last_d  = last_q;
        unique case (state_q)
            FILL: begin
                if (bus.s_valid) begin
                    lanes_d[idx_q] = bus.s_data;
                    if (close) begin
                        state_d = HOLD;
                        count_d = CW'(idx_q) + CW'(1);
                        last_d  = bus.s_last;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                // Whole buffer cleared so unused lanes read as zero.
                if (bus.m_ready) begin
                    state_d = FILL;
                    lanes_d = '0;
                    idx_d   = '0;
                    count_d = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            lanes_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lanes_q <= lanes_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign bus.s_ready = (state_q == FILL);
    assign bus.m_valid = (state_q == HOLD);
    assign bus.m_data  = lanes_q;
    assign bus.m_count = count_q;
    assign bus.m_last  = last_q;
endmodule

// File: tb/tb_tree_input_packer.sv
// Directed table plus corner sequences and a randomized
// sum scoreboard for tree_input_packer (W=32, N=4).
module tb_tree_input_packer;
    localparam int W = 32;
    localparam int N = 4;

    logic clk;
    logic rst;

    tree_input_packer_if #(.pDATA_WIDTH(W), .pINPUT_NUM(N)) bus();

    tree_input_packer #(.pDATA_WIDTH(W), .pINPUT_NUM(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic         l;
        logic         mr;
        logic         esr;
        logic         emv;
        logic [127:0] ed;
        logic         chkd;
        logic [2:0]   ec;
        logic         el;
    } vec_t;

    typedef struct {
        longint sum;
        int     cnt;
        bit     last;
    } grp_t;

    int     checks = 0;
    int     errors = 0;
    int     hs_cnt = 0;
    bit     rnd_on = 0;
    grp_t   sb[$];
    longint acc_sum = 0;
    int     acc_n = 0;
    int     grp_seen = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic v, logic [31:0] d, logic l,
                                logic mr, logic esr, logic emv,
                                logic [127:0] ed, logic chkd,
                                logic [2:0] ec, logic el);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.mr = mr;
        t.esr = esr; t.emv = emv; t.ed = ed;
        t.chkd = chkd; t.ec = ec; t.el = el;
        return t;
    endfunction

    task automatic drive(logic v, logic [31:0] d, logic l, logic mr);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.m_ready = mr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(string nm, logic esr, logic emv,
                           logic [127:0] ed, logic [2:0] ec, logic el);
        chk({nm, ".s_ready"}, 128'(bus.s_ready), 128'(esr));
        chk({nm, ".m_valid"}, 128'(bus.m_valid), 128'(emv));
        chk({nm, ".m_data"},  bus.m_data, ed);
        chk({nm, ".m_count"}, 128'(bus.m_count), 128'(ec));
        chk({nm, ".m_last"},  128'(bus.m_last), 128'(el));
    endtask

    // Observes handshakes mid-cycle, where inputs are settled.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.m_valid && bus.m_ready) hs_cnt++;
            if (rnd_on) begin
                if (bus.s_valid && bus.s_ready) begin
                    acc_sum += longint'($signed(bus.s_data));
                    acc_n++;
                    if (acc_n == N || bus.s_last) begin
                        sb.push_back('{acc_sum, acc_n, bus.s_last});
                        acc_sum = 0;
                        acc_n = 0;
                    end
                end
                if (bus.m_valid && bus.m_ready) begin
                    longint s;
                    grp_t   g;
                    s = 0;
                    for (int k = 0; k < N; k++)
                        s += longint'($signed(bus.m_data[k*W +: W]));
                    grp_seen++;
                    if (sb.size() == 0) begin
                        chk("rnd.unexpected_group", 128'(1), 128'(0));
                    end else begin
                        g = sb.pop_front();
                        chk("rnd.sum", 128'(s), 128'(g.sum));
                        chk("rnd.count", 128'(bus.m_count), 128'(g.cnt));
                        chk("rnd.last", 128'(bus.m_last), 128'(g.last));
                    end
                end
            end
        end
    end

    vec_t tbl[15];

    initial begin
        int hs0;
        int sent;
        int cyc;
        bit pend;
        bit acc;

        tbl[0]  = mk(1, 32'd1, 0, 1, 1, 0, 128'd0, 1, 3'd0, 0);
        tbl[1]  = mk(1, 32'd2, 0, 1, 1, 0, 128'd0, 0, 3'd0, 0);
        tbl[2]  = mk(1, 32'd3, 0, 1, 1, 0, 128'd0, 0, 3'd0, 0);
        tbl[3]  = mk(1, 32'd4, 0, 1, 1, 0, 128'd0, 0, 3'd0, 0);
        tbl[4]  = mk(0, 32'd0, 0, 1, 0, 1,
                     {32'd4, 32'd3, 32'd2, 32'd1}, 1, 3'd4, 0);
        tbl[5]  = mk(1, 32'd7, 0, 1, 1, 0, 128'd0, 1, 3'd0, 0);
        tbl[6]  = mk(1, 32'hFFFF_FFFE, 1, 1, 1, 0, 128'd0, 0, 3'd0, 0);
        tbl[7]  = mk(0, 32'd0, 0, 1, 0, 1,
                     {32'd0, 32'd0, 32'hFFFF_FFFE, 32'd7}, 1, 3'd2, 1);
        tbl[8]  = mk(1, 32'd5, 0, 1, 1, 0, 128'd0, 1, 3'd0, 0);
        tbl[9]  = mk(1, 32'd6, 0, 1, 1, 0, 128'd0, 0, 3'd0, 0);
        tbl[10] = mk(1, 32'd7, 0, 1, 1, 0, 128'd0, 0, 3'd0, 0);
        tbl[11] = mk(1, 32'd8, 1, 1, 1, 0, 128'd0, 0, 3'd0, 0);
        tbl[12] = mk(0, 32'd0, 0, 1, 0, 1,
                     {32'd8, 32'd7, 32'd6, 32'd5}, 1, 3'd4, 1);
        tbl[13] = mk(0, 32'd0, 0, 1, 1, 0, 128'd0, 1, 3'd0, 0);
        tbl[14] = mk(0, 32'd0, 0, 1, 1, 0, 128'd0, 1, 3'd0, 0);

        rst = 1'b0;
        drive(0, 32'd0, 0, 0);
        #1;
        chk_out("reset", 1, 0, 128'd0, 3'd0, 0);
        step();
        step();
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
            chk($sformatf("tbl%0d.s_ready", i),
                128'(bus.s_ready), 128'(tbl[i].esr));
            chk($sformatf("tbl%0d.m_valid", i),
                128'(bus.m_valid), 128'(tbl[i].emv));
            if (tbl[i].emv) begin
                chk($sformatf("tbl%0d.m_count", i),
                    128'(bus.m_count), 128'(tbl[i].ec));
                chk($sformatf("tbl%0d.m_last", i),
                    128'(bus.m_last), 128'(tbl[i].el));
            end
            if (tbl[i].chkd)
                chk($sformatf("tbl%0d.m_data", i), bus.m_data, tbl[i].ed);
            step();
        end

        // Back-pressure: group held for 6 cycles, HOLD inputs ignored.
        hs0 = hs_cnt;
        drive(1, 32'h11, 0, 0); step();
        drive(1, 32'h22, 0, 0); step();
        drive(1, 32'h33, 0, 0); step();
        drive(1, 32'h44, 0, 0); step();
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'hDEAD_0000 + 32'(i), i[0], 0);
            chk_out($sformatf("bp%0d", i), 0, 1,
                    {32'h44, 32'h33, 32'h22, 32'h11}, 3'd4, 0);
            step();
        end
        drive(0, 32'd0, 0, 1);
        chk_out("bp.release", 0, 1,
                {32'h44, 32'h33, 32'h22, 32'h11}, 3'd4, 0);
        step();
        chk_out("bp.after", 1, 0, 128'd0, 3'd0, 0);
        drive(1, 32'h55, 1, 1); step();
        drive(0, 32'd0, 0, 1);
        chk_out("bp.single", 0, 1, 128'h55, 3'd1, 1);
        step();
        step();
        chk("bp.handshakes", 128'(hs_cnt - hs0), 128'(2));

        // Reset mid-group discards the partial group.
        hs0 = hs_cnt;
        drive(1, 32'h91, 0, 1); step();
        drive(1, 32'h92, 0, 1); step();
        drive(0, 32'd0, 0, 1);
        rst = 1'b0;
        #1;
        chk_out("rst.mid", 1, 0, 128'd0, 3'd0, 0);
        step();
        rst = 1'b1;
        drive(1, 32'd9, 0, 1);  step();
        drive(1, 32'd10, 0, 1); step();
        drive(1, 32'd11, 0, 1); step();
        drive(1, 32'd12, 0, 1); step();
        drive(0, 32'd0, 0, 1);
        chk_out("rst.group", 0, 1,
                {32'd12, 32'd11, 32'd10, 32'd9}, 3'd4, 0);
        step(); step(); step();
        chk("rst.handshakes", 128'(hs_cnt - hs0), 128'(1));

        // Random back-pressure against the sum scoreboard.
        rnd_on = 1;
        sent = 0;
        cyc = 0;
        pend = 0;
        drive(0, 32'd0, 0, 0);
        while (sent < 1000 && cyc < 20000) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend = 1;
                bus.s_data = $urandom;
                bus.s_last = (sent == 999) || ($urandom_range(0, 4) == 0);
            end
            bus.s_valid = pend;
            bus.m_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            step();
            if (acc) begin
                pend = 0;
                sent++;
            end
            cyc++;
        end
        chk("rnd.sent", 128'(sent), 128'(1000));
        drive(0, 32'd0, 0, 1);
        for (int i = 0; i < 20 && (sb.size() != 0 || bus.m_valid); i++)
            step();
        chk("rnd.drained", 128'(sb.size()), 128'(0));
        chk("rnd.idle", 128'(bus.m_valid), 128'(0));
        chk("rnd.groups_seen", 128'(grp_seen > 200), 128'(1));
        rnd_on = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tree_input_packer.md
# tree_input_packer

Stream-to-parallel packer that feeds the adder tree in the ShuffleNet datapath. It accepts one signed operand per cycle on a valid/ready stream. It packs pINPUT_NUM operands into the wide lane bus consumed by the tree. It presents each completed group, zero-padded if the stream ends early, on an output valid/ready handshake that drives the tree's data_in/en pair.

## Interface
- pDATA_WIDTH, 32, width of one operand/lane
- pINPUT_NUM, 4, lanes per group (≥1); matches the downstream tree's input count
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset; all state cleared while low
- s_valid  input  1  upstream operand valid
- s_ready  output  1  packer can accept an operand this cycle
- s_data  input  pDATA_WIDTH  operand, two's complement
- s_last  input  1  operand is last of the current reduction; closes group early
- m_valid  output  1  packed group available
- m_ready  input  1  downstream consumes group this cycle
- m_data  output  pDATA_WIDTH*pINPUT_NUM  lane k at bits [k*pDATA_WIDTH +: pDATA_WIDTH]
- m_count  output  $clog2(pINPUT_NUM+1)  number of filled lanes in the presented group (1..pINPUT_NUM)
- m_last  output  1  presented group was closed by s_last

## Operation
- Two states: FILL (reset state) and HOLD.
- FILL: s_ready=1, m_valid=0. An operand is accepted when s_valid&&s_ready. It is written to lane idx (first operand → lane 0), and idx increments.
- FILL→HOLD when the accepted operand fills lane pINPUT_NUM-1 or carries s_last. m_count is set to idx+1. m_last is set to s_last of that operand.
- Lanes not written in the current group read as zero, which is the additive identity for the tree. The lane buffer is cleared on every group release, never by partial overwrite.
- HOLD: s_ready=0, m_valid=1. m_data, m_count and m_last are stable until handshake.
- HOLD→FILL on m_ready. Buffer cleared, idx=0, m_last=0, m_count=0.
- s_last together with lane pINPUT_NUM-1: a single full group is emitted with m_last=1. No empty trailing group is produced.
- s_valid while in HOLD is ignored (s_ready=0). Upstream must hold its data.
- pINPUT_NUM=1: every accepted operand moves directly to HOLD with m_count=1.
- Reset asserted mid-group or mid-HOLD: partial group discarded, state returns to FILL immediately. No output from the interrupted group is emitted after reset release.
- No arithmetic is performed; operands pass bit-exact to their lanes.

## Timing
- Reset values: s_ready=1 once FILL, m_valid=0, m_data=0, m_count=0, m_last=0.
- s_ready and m_valid are decoded from the registered state only. There are no combinational paths from s_valid or m_ready.
- Latency: m_valid rises on the cycle after the closing operand is accepted.
- Throughput: a full group takes pINPUT_NUM accept cycles + 1 or more HOLD cycles. With m_ready tied high, one group is produced per pINPUT_NUM+1 cycles.
- s_ready rises on the cycle after the m_valid&&m_ready handshake.
- Downstream pulses tree en for exactly the handshake cycle, with m_data as data_in.

## Test plan
- W=32, N=4; stream 1,2,3,4 with m_ready=1 → m_data={4,3,2,1} (lane3..lane0), m_count=4, m_last=0, m_valid high 1 cycle, 5 cycles total.
- Stream 7,-2 with s_last on -2 → m_data lanes {0,0,0xFFFFFFFE,7}, m_count=2, m_last=1; next group starts from lane 0.
- Full group with m_ready=0 for 6 cycles → s_ready=0 and m_data stable throughout; s_valid pulses in HOLD are not accepted. Release m_ready → single handshake, s_ready=1 next cycle.
- s_last on 4th operand (5,6,7,8) → one group, m_count=4, m_last=1; no further m_valid without new input.
- Accept 2 operands, pull rst low for 1 cycle, then stream 9,10,11,12 → only one group {12,11,10,9} is emitted. Outputs are zero during reset.
- Random s_valid/m_ready back-pressure over 1000 operands with random s_last → scoreboard sum of lanes per group equals reference sum per segment.
